hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
// - Producer of the stall/flush controls consumed by the PC, F/D and D/X pipeline registers.
// - Detects load-use hazards and taken-branch squashes.
// - Sequences multi-cycle mult/div ops sitting in X, with a timeout watchdog.
// - Keeps saturating stall/flush performance counters.
// PARAMETERS
// - CNT_W   32   width of stall_count / flush_count
// - MD_MAX  64   max cycles in MD_RUN before md_timeout; >=2
// PORTS
// - clock        in   1      single clock, rising edge
// - reset        in   1      asynchronous, active-low; 0 = reset
// - fd_rs        in   5      F/D source reg A
// - fd_rt        in   5      F/D source reg B
// - fd_uses_rt   in   1      F/D instruction reads fd_rt
// - dx_MemRead   in   1      D/X holds a load
// - dx_regDst    in   5      D/X destination reg
// - dx_is_md     in   1      D/X holds mul or div
// - take_branch  in   1      X resolved a taken branch/jump
// - md_ready     in   1      multdiv result valid (pulse)
// - cnt_clr      in   1      synchronous counter clear
// - stall_pc     out  1      hold PC
// - stall_fd     out  1      hold F/D
// - stall_dx     out  1      hold D/X
// - flush_fd     out  1      clear F/D
// - flush_dx     out  1      clear D/X (bubble)
// - md_start     out  1      one-cycle start pulse to multdiv unit
// - md_busy      out  1      state == MD_RUN
// - md_timeout   out  1      sticky watchdog flag
// - stall_count  out  CNT_W  cycles with stall_pc=1, saturating
// - flush_count  out  CNT_W  taken-branch flush cycles, saturating
// BEHAVIOUR
// - Reset (reset=0, async):
//   - state=IDLE; md_cnt, counters and md_timeout = 0.
//   - All control outputs are forced 0 while reset is low.
// - Load-use condition: lu = dx_MemRead & dx_regDst!=0 & (dx_regDst==fd_rs | fd_uses_rt & dx_regDst==fd_rt).
// - Outputs are combinational from state and inputs, evaluated in priority order:
//   1. take_branch: flush_fd=flush_dx=1, all stalls 0, md_start=0. lu and dx_is_md are ignored and the FSM stays in IDLE.
//   2. MD stall (IDLE & dx_is_md, or MD_RUN & !md_ready): stall_pc=stall_fd=stall_dx=1, flushes 0.
//   3. lu: stall_pc=stall_fd=1, flush_dx=1, stall_dx=0. Exactly one bubble per load-use.
//   4. Otherwise all 0.
// - FSM:
//   - IDLE -> MD_RUN when dx_is_md & !take_branch; md_start=1 in that same cycle (Mealy).
//   - MD_RUN & md_ready -> IDLE. Stall drops in the md_ready cycle, so D/X advances on that edge.
//   - MD_RUN & md_cnt==MD_MAX-1 & !md_ready -> IDLE, md_timeout<=1 (sticky until reset). That cycle still stalls.
//   - md_cnt clears on entering MD_RUN and increments each cycle in MD_RUN.
//   - md_ready in IDLE is ignored.
// - Back-to-back mult/div: the second op starts the cycle after return to IDLE; md_start pulses again.
// - Counters:
//   - stall_count += 1 when stall_pc; flush_count += 1 when take_branch.
//   - Both saturate at all-ones.
//   - cnt_clr wins over increment in the same cycle.
// - Latency: all hazard responses are same-cycle (combinational); only state/counters are registered.
// STRUCTURE
// - hazard_pkg:
//   - state encoding IDLE=1'b0, MD_RUN=1'b1.
//   - constants REG_ZERO=5'd0 and CNT_W default.
// - Sub-module sat_counter #(W) (clk, rst_n, clr, inc, q): instanced twice for the perf counters.
// - FSM, md_cnt and output priority logic live inline.
// TESTING
// - lw r5 in DX, FD reads rs=r5 -> one cycle of stall_pc=stall_fd=flush_dx=1, stall_dx=0; stall_count=1.
// - dx_regDst=0 with lu pattern, or fd_uses_rt=0 with rt match only -> no stall.
// - dx_is_md=1, md_ready on cycle 5:
//   - md_start=1 on cycle 0 only; stalls high cycles 0-4, low on cycle 5.
//   - md_busy cycles 1-5; stall_count=5.
// - MD_MAX=4, md_ready never asserted -> md_timeout=1 after 4 MD_RUN cycles; state returns to IDLE.
// - take_branch with lu and dx_is_md both high -> flush_fd=flush_dx=1, no stalls, md_start=0, flush_count=1.
// - Reset low mid-MD_RUN -> outputs 0 immediately.
//   After release: state IDLE, counters 0, no md_start unless dx_is_md.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    MD_RUN = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         CNT_W_DEF = 32;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a synchronous clear takes precedence over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush generator for PC, F/D and D/X: load-use bubbles, branch squash,
// multi-cycle mult/div sequencing with a watchdog, and saturating perf counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int MD_MAX = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       fd_rs,
  input  logic [4:0]       fd_rt,
  input  logic             fd_uses_rt,
  input  logic             dx_MemRead,
  input  logic [4:0]       dx_regDst,
  input  logic             dx_is_md,
  input  logic             take_branch,
  input  logic             md_ready,
  input  logic             cnt_clr,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             stall_dx,
  output logic             flush_fd,
  output logic             flush_dx,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int               MDC_W   = (MD_MAX > 2) ? $clog2(MD_MAX) : 1;
  localparam logic [MDC_W-1:0] MD_LAST = MDC_W'(MD_MAX - 1);

  md_state_e        state_q, state_d;
  logic [MDC_W-1:0] md_cnt_q, md_cnt_d;
  logic             timeout_q, timeout_d;

  logic lu, md_stall, start_c;
  logic stall_pc_c, stall_fd_c, stall_dx_c, flush_fd_c, flush_dx_c;

  assign lu = dx_MemRead && (dx_regDst != REG_ZERO) &&
              ((dx_regDst == fd_rs) || (fd_uses_rt && (dx_regDst == fd_rt)));

  // Handshake with the multdiv unit: md_start is a one-cycle pulse issued on
  // the IDLE->MD_RUN transition; md_ready is a one-cycle result-valid pulse
  // honoured only in MD_RUN, and the stall releases in that same cycle.
  always_comb begin
    state_d    = state_q;
    md_cnt_d   = md_cnt_q;
    timeout_d  = timeout_q;
    md_stall   = 1'b0;
    start_c    = 1'b0;
    stall_pc_c = 1'b0;
    stall_fd_c = 1'b0;
    stall_dx_c = 1'b0;
    flush_fd_c = 1'b0;
    flush_dx_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (dx_is_md && !take_branch) begin
          state_d  = MD_RUN;
          md_cnt_d = '0;
          start_c  = 1'b1;
          md_stall = 1'b1;
        end
      end
      MD_RUN: begin
        md_cnt_d = md_cnt_q + 1'b1;
        if (md_ready) begin
          state_d = IDLE;
        end else begin
          md_stall = 1'b1;
          if (md_cnt_q == MD_LAST) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_branch) begin
      flush_fd_c = 1'b1;
      flush_dx_c = 1'b1;
    end else if (md_stall) begin
      stall_pc_c = 1'b1;
      stall_fd_c = 1'b1;
      stall_dx_c = 1'b1;
    end else if (lu) begin
      stall_pc_c = 1'b1;
      stall_fd_c = 1'b1;
      flush_dx_c = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      md_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Controls are gated so nothing leaks out while reset is held low.
  assign stall_pc   = reset & stall_pc_c;
  assign stall_fd   = reset & stall_fd_c;
  assign stall_dx   = reset & stall_dx_c;
  assign flush_fd   = reset & flush_fd_c;
  assign flush_dx   = reset & flush_dx_c;
  assign md_start   = reset & start_c;
  assign md_busy    = reset & (state_q == MD_RUN);
  assign md_timeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clock),
    .rst_n (reset),
    .clr   (cnt_clr),
    .inc   (stall_pc),
    .q     (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clock),
    .rst_n (reset),
    .clr   (cnt_clr),
    .inc   (take_branch),
    .q     (flush_count)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a full-size instance plus a small one
// (4-bit counters, MD_MAX=4) for watchdog and saturation corners.
module tb_hazard_stall_ctrl;
  import hazard_pkg::*;

  // {stall_pc, stall_fd, stall_dx, flush_fd, flush_dx, md_start, md_busy}
  localparam logic [6:0] C_NONE = 7'b000_00_0_0;
  localparam logic [6:0] C_LU   = 7'b110_01_0_0;
  localparam logic [6:0] C_BR   = 7'b000_11_0_0;
  localparam logic [6:0] C_MDS  = 7'b111_00_1_0;
  localparam logic [6:0] C_MDR  = 7'b111_00_0_1;
  localparam logic [6:0] C_RDY  = 7'b000_00_0_1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] fd_rs = '0, fd_rt = '0, dx_regDst = '0;
  logic       fd_uses_rt = 1'b0, dx_MemRead = 1'b0, dx_is_md = 1'b0;
  logic       take_branch = 1'b0, md_ready = 1'b0, cnt_clr = 1'b0;

  logic        m_spc, m_sfd, m_sdx, m_ffd, m_fdx, m_start, m_busy, m_to;
  logic [31:0] m_sc, m_fc;
  logic        s_spc, s_sfd, s_sdx, s_ffd, s_fdx, s_start, s_busy, s_to;
  logic [3:0]  s_sc, s_fc;

  logic [6:0] m_ctl, s_ctl;
  assign m_ctl = {m_spc, m_sfd, m_sdx, m_ffd, m_fdx, m_start, m_busy};
  assign s_ctl = {s_spc, s_sfd, s_sdx, s_ffd, s_fdx, s_start, s_busy};

  hazard_stall_ctrl u_dut (
    .clock(clock), .reset(reset), .fd_rs(fd_rs), .fd_rt(fd_rt),
    .fd_uses_rt(fd_uses_rt), .dx_MemRead(dx_MemRead), .dx_regDst(dx_regDst),
    .dx_is_md(dx_is_md), .take_branch(take_branch), .md_ready(md_ready),
    .cnt_clr(cnt_clr), .stall_pc(m_spc), .stall_fd(m_sfd), .stall_dx(m_sdx),
    .flush_fd(m_ffd), .flush_dx(m_fdx), .md_start(m_start), .md_busy(m_busy),
    .md_timeout(m_to), .stall_count(m_sc), .flush_count(m_fc)
  );

  hazard_stall_ctrl #(.CNT_W(4), .MD_MAX(4)) u_small (
    .clock(clock), .reset(reset), .fd_rs(fd_rs), .fd_rt(fd_rt),
    .fd_uses_rt(fd_uses_rt), .dx_MemRead(dx_MemRead), .dx_regDst(dx_regDst),
    .dx_is_md(dx_is_md), .take_branch(take_branch), .md_ready(md_ready),
    .cnt_clr(cnt_clr), .stall_pc(s_spc), .stall_fd(s_sfd), .stall_dx(s_sdx),
    .flush_fd(s_ffd), .flush_dx(s_fdx), .md_start(s_start), .md_busy(s_busy),
    .md_timeout(s_to), .stall_count(s_sc), .flush_count(s_fc)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Scoreboard
  logic [6:0]  exp_q[$];
  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_sc = '0, exp_fc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver: inputs already applied; check main controls mid-cycle, advance one edge.
  task automatic step(input string name, input logic [6:0] exp);
    logic [6:0] e;
    exp_q.push_back(exp);
    @(negedge clock);
    e = exp_q.pop_front();
    chk(name, {25'd0, m_ctl}, {25'd0, e});
    if (e[6]) exp_sc++;
    if (take_branch) exp_fc++;
    @(posedge clock); #1;
  endtask

  task automatic clear_inputs();
    fd_rs = '0; fd_rt = '0; dx_regDst = '0; fd_uses_rt = 1'b0;
    dx_MemRead = 1'b0; dx_is_md = 1'b0; take_branch = 1'b0;
    md_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    exp_sc = '0;
    exp_fc = '0;
  endtask

  typedef struct {
    string      name;
    logic [4:0] rs, rt, dst;
    logic       uses_rt, mem_rd, br;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] sc_before, fc_before;

  initial begin
    vecs[0] = '{"lu_rs",        5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, C_LU};
    vecs[1] = '{"dst_zero",     5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, C_NONE};
    vecs[2] = '{"rt_unused",    5'd1, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, C_NONE};
    vecs[3] = '{"lu_rt",        5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, C_LU};
    vecs[4] = '{"no_load",      5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, C_NONE};
    vecs[5] = '{"br_over_lu",   5'd3, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1, C_BR};
    vecs[6] = '{"no_match",     5'd2, 5'd4, 5'd6, 1'b1, 1'b1, 1'b0, C_NONE};
    vecs[7] = '{"br_only",      5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_BR};

    // Controls stay low during reset even with hazards present.
    dx_is_md = 1'b1; take_branch = 1'b1;
    dx_MemRead = 1'b1; dx_regDst = 5'd5; fd_rs = 5'd5;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ctl", {25'd0, m_ctl}, 32'd0);
    chk("rst_stall_cnt", m_sc, 32'd0);
    chk("rst_flush_cnt", m_fc, 32'd0);
    chk("rst_timeout", {31'd0, m_to}, 32'd0);
    clear_inputs();
    @(posedge clock); #1;
    reset = 1'b1;

    // Table-driven single-cycle hazards.
    for (int i = 0; i < 8; i++) begin
      fd_rs = vecs[i].rs; fd_rt = vecs[i].rt; dx_regDst = vecs[i].dst;
      fd_uses_rt = vecs[i].uses_rt; dx_MemRead = vecs[i].mem_rd;
      take_branch = vecs[i].br;
      step(vecs[i].name, vecs[i].exp);
      if (i == 0) chk("lu_stall_cnt_1", m_sc, 32'd1);
    end
    clear_inputs();
    chk("tbl_stall_cnt", m_sc, exp_sc);
    chk("tbl_flush_cnt", m_fc, exp_fc);

    // Mult/div: ready on cycle 5, then a back-to-back op.
    sc_before = m_sc;
    dx_is_md = 1'b1;
    step("md_c0", C_MDS);
    for (int c = 1; c <= 4; c++) step($sformatf("md_c%0d", c), C_MDR);
    md_ready = 1'b1;
    step("md_c5", C_RDY);
    md_ready = 1'b0;
    chk("md_stall_delta", m_sc - sc_before, 32'd5);
    step("b2b_start", C_MDS);
    md_ready = 1'b1;
    step("b2b_ready", C_RDY);
    clear_inputs();
    chk("md_stall_cnt", m_sc, exp_sc);

    // md_ready while idle is ignored.
    md_ready = 1'b1;
    step("rdy_idle", C_NONE);
    md_ready = 1'b0;
    step("rdy_idle_after", C_NONE);

    // Branch outranks both load-use and mult/div.
    fc_before = m_fc;
    dx_MemRead = 1'b1; dx_regDst = 5'd5; fd_rs = 5'd5;
    dx_is_md = 1'b1; take_branch = 1'b1;
    step("br_prio", C_BR);
    clear_inputs();
    step("br_after", C_NONE);
    chk("br_flush_delta", m_fc - fc_before, 32'd1);

    // Reset dropped in the middle of MD_RUN.
    dx_is_md = 1'b1;
    step("mid_start", C_MDS);
    step("mid_run", C_MDR);
    reset = 1'b0;
    #1;
    chk("mid_rst_ctl", {25'd0, m_ctl}, 32'd0);
    chk("mid_rst_stall_cnt", m_sc, 32'd0);
    chk("mid_rst_flush_cnt", m_fc, 32'd0);
    @(posedge clock); #1;
    dx_is_md = 1'b0;
    reset = 1'b1;
    exp_sc = '0; exp_fc = '0;
    step("post_rst_idle", C_NONE);
    chk("post_rst_cnt", m_sc, 32'd0);

    // Watchdog on the MD_MAX=4 instance.
    dx_is_md = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clock);
      chk($sformatf("to_ctl_c%0d", c), {25'd0, s_ctl},
          {25'd0, (c == 0) ? C_MDS : (c <= 4) ? C_MDR : C_NONE});
      chk($sformatf("to_flag_c%0d", c), {31'd0, s_to}, (c <= 4) ? 32'd0 : 32'd1);
      @(posedge clock); #1;
      dx_is_md = 1'b0;
    end
    chk("to_stall_cnt", {28'd0, s_sc}, 32'd5);

    // Saturation, then clear winning over a concurrent increment.
    pulse_reset();
    dx_MemRead = 1'b1; dx_regDst = 5'd8; fd_rs = 5'd8;
    for (int c = 0; c < 20; c++) step("sat_lu", C_LU);
    chk("sat_main_cnt", m_sc, exp_sc);
    chk("sat_small_cnt", {28'd0, s_sc}, 32'd15);
    cnt_clr = 1'b1;
    step("clr_lu", C_LU);
    exp_sc = '0;
    chk("clr_main_cnt", m_sc, 32'd0);
    chk("clr_small_cnt", {28'd0, s_sc}, 32'd0);
    cnt_clr = 1'b0;
    step("after_clr_lu", C_LU);
    chk("after_clr_cnt", m_sc, exp_sc);
    clear_inputs();

    // Report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
